// File: rtl/blt_bus_arbiter_if.sv
// Shared bus bundle between the 6809 CPU, the sc1 blitter, memory and blt_bus_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface blt_bus_arbiter_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic              e_sync;
  logic              cpu_ba;
  logic              cpu_bs;
  logic              cpu_halt;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_data_out;
  logic              blt_halt;
  logic              blt_halt_ack;
  logic [ADDR_W-1:0] blt_address_out;
  logic              blt_read;
  logic              blt_write;
  logic [DATA_W-1:0] blt_data_out;
  logic              en_upper;
  logic              en_lower;
  logic              blt_ack;
  logic [DATA_W-1:0] blt_data_in;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_en_upper;
  logic              mem_en_lower;
  logic [DATA_W-1:0] mem_data_in;
  logic              arb_timeout;

  modport slave (
    input  e_sync, cpu_ba, cpu_bs, cpu_address, cpu_read, cpu_write, cpu_data_out,
    input  blt_halt, blt_address_out, blt_read, blt_write, blt_data_out,
    input  en_upper, en_lower, mem_data_in,
    output cpu_halt, blt_halt_ack, blt_ack, blt_data_in,
    output mem_address, mem_read, mem_write, mem_data_out, mem_en_upper, mem_en_lower,
    output arb_timeout
  );

  modport master (
    output e_sync, cpu_ba, cpu_bs, cpu_address, cpu_read, cpu_write, cpu_data_out,
    output blt_halt, blt_address_out, blt_read, blt_write, blt_data_out,
    output en_upper, en_lower, mem_data_in,
    input  cpu_halt, blt_halt_ack, blt_ack, blt_data_in,
    input  mem_address, mem_read, mem_write, mem_data_out, mem_en_upper, mem_en_lower,
    input  arb_timeout
  );
endinterface

// File: rtl/blt_bus_arbiter.sv
// Hands the video/program memory bus between the 6809 and the sc1 blitter.
// Optional halt-acknowledge timeout enabled by defining BLT_TIMEOUT_EN.
module blt_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned TIMEOUT_E     = 16
) (
  input  logic               clk,
  input  logic               reset,
  blt_bus_arbiter_if.slave   bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TO_W   = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_REQ,
    S_GRANT,
    S_ACCESS,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t            r_state;
  logic              r_cpu_halt;
  logic              r_blt_halt_ack;
  logic              r_blt_ack;
  logic [DATA_W-1:0] r_blt_data_in;
  logic [ADDR_W-1:0] r_lat_addr;
  logic [DATA_W-1:0] r_lat_data;
  logic              r_lat_en_upper;
  logic              r_lat_en_lower;
  logic              r_lat_read;
  logic              r_lat_write;
  logic [CNT_W-1:0]  r_acc_cnt;

  logic              w_halt_ok;
  logic              w_cpu_resumed;
  logic              w_blt_strobe;
  logic              w_blt_owned;
  logic              w_strobe_on;

`ifdef BLT_TIMEOUT_EN
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_arb_timeout;
`else
  logic              w_unused_timeout;
  assign w_unused_timeout = ^TO_W'(TIMEOUT_E);
`endif

  assign w_halt_ok     = bus.e_sync & bus.cpu_ba & bus.cpu_bs;
  assign w_cpu_resumed = bus.e_sync & ~bus.cpu_ba;
  assign w_blt_strobe  = bus.blt_read | bus.blt_write;

  // Ownership sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cpu_halt     <= 1'b0;
      r_blt_halt_ack <= 1'b0;
      r_blt_ack      <= 1'b0;
      r_blt_data_in  <= '0;
      r_lat_addr     <= '0;
      r_lat_data     <= '0;
      r_lat_en_upper <= 1'b0;
      r_lat_en_lower <= 1'b0;
      r_lat_read     <= 1'b0;
      r_lat_write    <= 1'b0;
      r_acc_cnt      <= '0;
`ifdef BLT_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_arb_timeout  <= 1'b0;
`endif
    end else begin
      r_blt_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.blt_halt) begin
            r_state    <= S_HALT_REQ;
            r_cpu_halt <= 1'b1;
`ifdef BLT_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
          end
        end
        S_HALT_REQ: begin
          // Acknowledge has priority over a timeout on the same E boundary
          if (w_halt_ok) begin
            r_state        <= S_GRANT;
            r_blt_halt_ack <= 1'b1;
          end
`ifdef BLT_TIMEOUT_EN
          else if (bus.e_sync) begin
            if (r_to_cnt == TO_W'(TIMEOUT_E - 1)) begin
              r_state       <= S_RELEASE;
              r_cpu_halt    <= 1'b0;
              r_arb_timeout <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
`endif
        end
        S_GRANT: begin
          // A pending strobe wins over a dropped halt
          if (w_blt_strobe) begin
            r_state        <= S_ACCESS;
            r_lat_addr     <= bus.blt_address_out;
            r_lat_data     <= bus.blt_data_out;
            r_lat_en_upper <= bus.en_upper;
            r_lat_en_lower <= bus.en_lower;
            r_lat_write    <= bus.blt_write;
            r_lat_read     <= ~bus.blt_write;
            r_acc_cnt      <= CNT_W'(ACCESS_CYCLES - 1);
          end else if (!bus.blt_halt) begin
            r_state        <= S_RELEASE;
            r_cpu_halt     <= 1'b0;
            r_blt_halt_ack <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (r_acc_cnt == '0) begin
            r_state   <= S_ACK;
            r_blt_ack <= 1'b1;
            if (r_lat_read) r_blt_data_in <= bus.mem_data_in;
          end else begin
            r_acc_cnt <= r_acc_cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          r_state <= S_GRANT;
        end
        S_RELEASE: begin
          if (w_cpu_resumed) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_blt_owned = (r_state == S_GRANT) || (r_state == S_ACCESS) || (r_state == S_ACK);
  assign w_strobe_on = (r_state == S_ACCESS);

  // Memory-side mux: CPU passes straight through unless the blitter owns the bus
  always_comb begin
    bus.mem_address  = bus.cpu_address;
    bus.mem_read     = bus.cpu_read;
    bus.mem_write    = bus.cpu_write;
    bus.mem_data_out = bus.cpu_data_out;
    bus.mem_en_upper = bus.cpu_write;
    bus.mem_en_lower = bus.cpu_write;
    if (w_blt_owned) begin
      bus.mem_address  = r_lat_addr;
      bus.mem_read     = w_strobe_on & r_lat_read;
      bus.mem_write    = w_strobe_on & r_lat_write;
      bus.mem_data_out = r_lat_data;
      bus.mem_en_upper = r_lat_en_upper;
      bus.mem_en_lower = r_lat_en_lower;
    end
  end

  assign bus.cpu_halt     = r_cpu_halt;
  assign bus.blt_halt_ack = r_blt_halt_ack;
  assign bus.blt_ack      = r_blt_ack;
  assign bus.blt_data_in  = r_blt_data_in;
`ifdef BLT_TIMEOUT_EN
  assign bus.arb_timeout  = r_arb_timeout;
`else
  assign bus.arb_timeout  = 1'b0;
`endif

endmodule

// File: doc/blt_bus_arbiter.md
# blt_bus_arbiter

Sequences ownership of the shared video/program memory bus between the 6809 CPU and the sc1 blitter. On a blitter halt request it halts the CPU and waits for the 6809 halt acknowledge (BA=BS=1) on an E-cycle boundary. It then grants the bus to the blitter, runs each blitter read/write as a timed memory access terminated by a one-cycle `blt_ack`, and returns the bus to the CPU when the blitter drops `halt`. It sits between the CPU core, the sc1 instance and the memory/nibble-mask write logic.

## Interface
Parameters:
- `ACCESS_CYCLES`, 2: clocks a memory strobe is held per blitter access; legal 1..15.
- `TIMEOUT_E`, 16: e_sync pulses allowed for the CPU halt acknowledge (used only with `BLT_TIMEOUT_EN`); legal 1..255.

Ports:
- `clk` in 1: system clock (12 MHz); the only clock.
- `reset` in 1: synchronous, active-high.
- `e_sync` in 1: one-clock pulse marking each 6809 E-cycle boundary.
- `cpu_ba`, `cpu_bs` in 1 each: 6809 bus status.
- `cpu_halt` out 1: active-high halt request to the CPU.
- `cpu_address` in 16: CPU memory address.
- `cpu_read`, `cpu_write` in 1 each: CPU memory strobes.
- `cpu_data_out` in 8: CPU write data.
- `blt_halt` in 1: blitter bus request.
- `blt_halt_ack` out 1: bus granted to the blitter.
- `blt_address_out` in 16: blitter access address.
- `blt_read`, `blt_write` in 1 each: blitter access strobes.
- `blt_data_out` in 8: blitter write data.
- `en_upper`, `en_lower` in 1 each: blitter nibble write enables.
- `blt_ack` out 1: access-complete pulse.
- `blt_data_in` out 8: read data returned to the blitter.
- `mem_address` out 16: memory address.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `mem_data_out` out 8: memory write data.
- `mem_en_upper`, `mem_en_lower` out 1 each: nibble enables.
- `mem_data_in` in 8: memory read data.
- `arb_timeout` out 1: sticky halt-acknowledge timeout flag.

## Operation
- States:
  - IDLE: CPU owns the bus.
  - HALT_REQ: `cpu_halt`=1; CPU still owns the bus.
  - GRANT: `cpu_halt`=1, `blt_halt_ack`=1; blitter owns the bus, no strobe.
  - ACCESS: strobe active for `ACCESS_CYCLES`.
  - ACK: `blt_ack`=1.
  - RELEASE: `cpu_halt`=0; waiting for the CPU to resume.
- Transitions:
  - IDLE→HALT_REQ: when `blt_halt`=1.
  - HALT_REQ→GRANT: on a clock with `e_sync & cpu_ba & cpu_bs`.
  - GRANT→ACCESS: when `blt_read|blt_write`. Address, data and enables are latched at this edge. If both strobes are high, the access is a write.
  - GRANT→RELEASE: when `blt_halt`=0 and no strobe is present. A strobe wins over a dropped halt.
  - ACCESS→ACK: after `ACCESS_CYCLES` clocks.
  - ACK→GRANT: unconditional.
  - RELEASE→IDLE: on `e_sync & ~cpu_ba`.
- `blt_halt` deasserted during ACCESS/ACK: the access completes; the FSM then leaves via GRANT→RELEASE.
- `blt_halt` reasserted in RELEASE: ignored until IDLE, then re-requested.
- Bus mux:
  - IDLE, HALT_REQ, RELEASE: `mem_*` follows the CPU combinationally. Nibble enables are both 1 for CPU writes.
  - GRANT, ACK: `mem_*` is driven from the blitter latches with strobes low.
  - ACCESS: `mem_*` is driven from the blitter latches with the selected strobe high.
- Read data: `mem_data_in` is captured into `blt_data_in` on the last ACCESS clock. It holds until the next read completes.
- Blitter strobes seen during ACCESS/ACK are ignored. The blitter must drop or renew its strobe in response to `blt_ack`.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_halt`, `blt_halt_ack`, `blt_ack`, `arb_timeout`, latched strobes: 0.
  - `blt_data_in`, blitter address/data latches: 0.
- Reset mid-operation releases the CPU on the next edge. Any in-flight access is abandoned without `blt_ack`.
- `cpu_halt` goes high on the first clock after `blt_halt` is sampled high.
- `blt_halt_ack` goes high on the clock after the qualifying `e_sync`.
- Access cost is `ACCESS_CYCLES`+2 clocks: GRANT sample, N ACCESS, 1 ACK.
  - Back-to-back accesses at default settings: one `blt_ack` every 4 clocks.
- `blt_ack` is exactly one clock wide, concurrent with valid `blt_data_in`.
- `blt_halt_ack` falls on the clock GRANT→RELEASE is taken, together with `cpu_halt`.
- Access counter: 4-bit; loads `ACCESS_CYCLES`-1 on entry to ACCESS and exits at 0. It cannot wrap.

## Configuration
- Macro `BLT_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter, cleared on entry to HALT_REQ, counts `e_sync` pulses in HALT_REQ.
  - When it reaches `TIMEOUT_E` without acknowledge, the FSM goes to RELEASE and `arb_timeout` sets. It stays set until `reset`.
  - Acknowledge and timeout on the same `e_sync`: acknowledge wins.
- Undefined:
  - No counter; HALT_REQ waits indefinitely.
  - `arb_timeout` is tied 0.

## Test plan
- Grant handshake: `blt_halt`=1; BA=BS=1 while `e_sync` pulses every 12 clocks.
  - Required: `cpu_halt`=1 next clock; `blt_halt_ack`=1 one clock after the first `e_sync` with BA=BS=1.
- Blitter read at defaults: GRANT, `blt_read`=1, addr 16'h1234, `mem_data_in`=8'h69.
  - Required: `mem_read`=1 for 2 clocks with `mem_address`=16'h1234.
  - Required: `blt_ack` is one clock wide and `blt_data_in`=8'h69 on that clock.
- Blitter write with mask: `blt_write`=1, `blt_data_out`=8'hA5, `en_upper`=0, `en_lower`=1.
  - Required: `mem_write` for 2 clocks, `mem_data_out`=8'hA5, `mem_en_upper`=0, `mem_en_lower`=1.
- Release: `blt_halt`=0 during ACCESS.
  - Required: the access still completes with `blt_ack`; then `cpu_halt`=`blt_halt_ack`=0; IDLE after the next `e_sync` with `cpu_ba`=0.
- Reset mid-access: `reset`=1 during ACCESS.
  - Required: next clock all outputs 0, no `blt_ack`, CPU addresses appear on `mem_address`.
- Timeout (`BLT_TIMEOUT_EN`, `TIMEOUT_E`=4): `cpu_ba`=0 throughout.
  - Required: after the 4th `e_sync`, `arb_timeout`=1 and `cpu_halt`=0; `blt_halt_ack` never asserts.
